// File: rtl/clk_div_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// State encoding plus nominal divider constants.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  localparam int HALF_PERIOD_DEF = 2;
  localparam int LOCK_COUNT_DEF  = 4;
  localparam int ERR_CNT_MAX     = 255;

endpackage

// File: rtl/clk_div_monitor_edge_sync.sv
// Synchronizes the divided clock into the fast domain and
// flags its edges, with registered one-cycle rise/fall pulses.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_det,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];
  assign edge_det = sync_out ^ prev;

  // Synchronizer chain, history flop and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync       <= '0;
      prev       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev       <= sync_out;
      rise_pulse <= sync_out & ~prev;
      fall_pulse <= ~sync_out & prev;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures half-periods of div_clk,
// declares lock after a good run, counts later deviations.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_cnt,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] HP =
    CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] TO =
    CNT_W'(2 * HALF_PERIOD + 1);
  localparam logic [GW-1:0] LC1 =
    GW'(LOCK_COUNT - 1);
  localparam logic [7:0] EMAX =
    8'(ERR_CNT_MAX);

  state_t           state, state_nx;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] half_nx;
  logic [GW-1:0]    good_cnt, good_nx;
  logic [7:0]       ecnt_nx;
  logic             err_nx;
  logic             bump;
  logic             edge_det;
  logic             good;
  logic             tmo;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .din       (div_clk),
    .edge_det  (edge_det),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // An edge coinciding with the timeout value counts as
  // an (over-long) edge, never as a stall.
  assign good   = (run_cnt == HP);
  assign tmo    = !edge_det && (run_cnt == TO);
  assign locked = (state == LOCKED);

  // Cycles since the last edge, saturating.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cnt <= '0;
    end else if (edge_det) begin
      run_cnt <= CNT_W'(1);
    end else if (run_cnt != '1) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // FSM and measurement/error registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      half_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
      half_cnt <= half_nx;
      err      <= err_nx;
      err_cnt  <= ecnt_nx;
    end
  end

  // Next-state: first edge in IDLE is discarded as partial.
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    half_nx  = half_cnt;
    err_nx   = err;
    ecnt_nx  = err_cnt;
    bump     = 1'b0;
    unique case (state)
      IDLE: begin
        if (edge_det) begin
          state_nx = TRACK;
          good_nx  = '0;
        end
      end
      TRACK: begin
        if (edge_det) begin
          half_nx = run_cnt;
          if (!good) begin
            good_nx = '0;
          end else if (good_cnt == LC1) begin
            state_nx = LOCKED;
            good_nx  = '0;
          end else begin
            good_nx = good_cnt + 1'b1;
          end
        end else if (tmo) begin
          state_nx = IDLE;
          good_nx  = '0;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          half_nx = run_cnt;
          if (!good) begin
            state_nx = TRACK;
            good_nx  = '0;
            bump     = 1'b1;
          end
        end else if (tmo) begin
          state_nx = IDLE;
          good_nx  = '0;
          bump     = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        good_nx  = '0;
      end
    endcase
    if (bump) begin
      err_nx = 1'b1;
      if (err_cnt != EMAX) begin
        ecnt_nx = err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor (HP=2, LOCK=4, SYNC=2).
// Expected per-edge values are queued as toggles are issued.
module tb_clk_div_monitor;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       div_clk = 1'b0;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] half_cnt;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  clk_div_monitor #(
    .HALF_PERIOD(2),
    .LOCK_COUNT (4),
    .SYNC_STAGES(2),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .div_clk   (div_clk),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .half_cnt  (half_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] hc;
    logic       lk;
    logic       er;
    logic [7:0] ec;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] hist   = '0;
  bit         pchk   = 1'b0;
  bit         sb     = 1'b0;
  int         hi_cnt = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  // One clk cycle; pulses are checked against the input
  // history delayed by the synchronizer latency.
  task automatic step();
    exp_t e;
    hist = {hist[2:0], div_clk};
    @(posedge clk);
    #1;
    if (locked) hi_cnt++;
    if (pchk) begin
      check("rise", 32'(rise_pulse),
            32'(hist[2] & ~hist[3]));
      check("fall", 32'(fall_pulse),
            32'(~hist[2] & hist[3]));
    end
    if (sb && (rise_pulse || fall_pulse)) begin
      check("edge_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("half_cnt", 32'(half_cnt), 32'(e.hc));
        check("locked", 32'(locked), 32'(e.lk));
        check("err", 32'(err), 32'(e.er));
        check("err_cnt", 32'(err_cnt), 32'(e.ec));
      end
    end
  endtask

  // Toggle, queue what this edge must show, hold n cycles.
  task automatic tog(input int n, input int hc,
                     input int lk, input int er,
                     input int ec);
    exp_t e;
    e.hc = 8'(hc);
    e.lk = lk[0];
    e.er = er[0];
    e.ec = 8'(ec);
    div_clk = ~div_clk;
    if (sb) q.push_back(e);
    repeat (n) step();
  endtask

  task automatic outs_zero(input string tag);
    check(tag, 32'({rise_pulse, fall_pulse, half_cnt,
                    locked, err, err_cnt}), 0);
  endtask

  initial begin
    // Reset held while div_clk toggles.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      div_clk = ~div_clk;
      step();
      outs_zero("in_reset");
    end
    div_clk = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      outs_zero("idle_static");
    end

    pchk = 1'b1;
    sb   = 1'b1;

    // Ideal divide-by-4: lock on 5th edge.
    tog(2, 0, 0, 0, 0);
    repeat (3) tog(2, 2, 0, 0, 0);
    repeat (4) tog(2, 2, 1, 0, 0);
    // One stretched half-period, then relock.
    tog(3, 2, 1, 0, 0);
    tog(2, 3, 0, 1, 1);
    repeat (3) tog(2, 2, 0, 1, 1);
    tog(2, 2, 1, 1, 1);
    // Stall: timeout 5 cycles after the last edge.
    tog(7, 2, 1, 1, 1);
    check("pre_timeout_locked", 32'(locked), 1);
    step();
    check("timeout_locked", 32'(locked), 0);
    check("timeout_err", 32'(err), 1);
    check("timeout_err_cnt", 32'(err_cnt), 2);
    repeat (4) step();
    // Resume: first edge discarded, then 4 good.
    repeat (4) tog(2, 2, 0, 1, 2);
    tog(2, 2, 1, 1, 2);
    // Edge exactly at timeout value is a bad edge.
    tog(5, 2, 1, 1, 2);
    tog(2, 5, 0, 1, 3);
    repeat (3) tog(2, 2, 0, 1, 3);
    tog(2, 2, 1, 1, 3);
    repeat (4) step();
    check("edges_left", 32'(q.size()), 0);
    check("locked_before_reset", 32'(locked), 1);

    // Single-cycle reset while locked.
    div_clk = 1'b0;
    reset   = 1'b0;
    step();
    reset = 1'b1;
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_half_cnt", 32'(half_cnt), 0);
    repeat (2) step();

    // Repeated lock/err cycles to saturate err_cnt.
    sb = 1'b0;
    repeat (5) tog(2, 0, 0, 0, 0);
    for (int l = 1; l <= 260; l++) begin
      tog(3, 0, 0, 0, 0);
      repeat (4) tog(2, 0, 0, 0, 0);
      if (l == 10)
        check("err_cnt_10", 32'(err_cnt), 10);
      if (l == 255)
        check("err_cnt_255", 32'(err_cnt), 255);
    end
    check("err_cnt_sat", 32'(err_cnt), 255);
    check("err_sticky", 32'(err), 1);

    // Constant 3-cycle half-period never relocks.
    repeat (10) tog(3, 0, 0, 0, 0);
    hi_cnt = 0;
    repeat (290) tog(3, 0, 0, 0, 0);
    check("never_relock", 32'(hi_cnt), 0);
    check("err_cnt_nowrap", 32'(err_cnt), 255);
    check("half_cnt_3", 32'(half_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
